// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl: machine-mode trap sequencer between the pipeline and the CSR file.
//
// Accepts synchronous exceptions, mret and the MEI/MSI/MTI interrupt lines. It
// produces the trap-state writes (mepc, mcause, mtval, mstatus.MIE/MPIE),
// stalls and flushes the pipeline and redirects the PC to the mtvec target or
// to mepc.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   exc_valid/cause/pc/tval  synchronous exception from the pipeline
//   mret_valid               mret has reached execute
//   int_ok, int_pc           clean boundary for interrupts, next-instruction PC
//   irq_ext/sw/timer         asynchronous interrupt request levels
//   mstatus_mie/mpie, mie,
//   mtvec, mepc              current CSR values
//   csr_trap_we, csr_*_o     one-cycle write of mepc/mcause/mtval
//   csr_mstat_we, mie_next,
//   mpie_next                one-cycle write of mstatus.MIE/MPIE
//   mip_o                    synchronized pending bits (11 MEI, 7 MTI, 3 MSI)
//   stall, flush, redirect,
//   redirect_pc              pipeline control
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2,
  parameter int VECTORED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic            int_ok,
  input  logic [XLEN-1:0] int_pc,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            csr_trap_we,
  output logic [XLEN-1:0] csr_mepc_o,
  output logic [XLEN-1:0] csr_mcause_o,
  output logic [XLEN-1:0] csr_mtval_o,
  output logic            csr_mstat_we,
  output logic            mie_next,
  output logic            mpie_next,
  output logic [XLEN-1:0] mip_o,
  output logic            stall,
  output logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAVE  = 2'd1,
    ST_REDIR = 2'd2,
    ST_MRET  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  // Synchronizer chain; bit order {ext, sw, timer}
  logic [2:0]      sync_q [SYNC_STAGES];
  logic [2:0]      sync_d [SYNC_STAGES];

  logic [XLEN-1:0] mip_s;
  logic [XLEN-1:0] pend_s;
  logic            int_any_s;
  logic [3:0]      int_code_s;
  logic [XLEN-1:0] tvec_base_s;
  logic [XLEN-1:0] tvec_tgt_s;
  logic            unused_s;

  // Low PC bits are always forced to zero, so they are never consumed
  assign unused_s = &{1'b0, exc_pc[1:0], int_pc[1:0], mepc[1:0]};

  // Shift the raw irq levels through the synchronizer chain
  always_comb begin
    sync_d[0] = {irq_ext, irq_sw, irq_timer};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 3'b000;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  // Pending/enabled interrupt decode with fixed MEI > MSI > MTI priority
  always_comb begin
    mip_s     = {XLEN{1'b0}};
    mip_s[11] = sync_q[SYNC_STAGES-1][2];
    mip_s[3]  = sync_q[SYNC_STAGES-1][1];
    mip_s[7]  = sync_q[SYNC_STAGES-1][0];
    pend_s    = mip_s & mie & {XLEN{mstatus_mie}};
    int_any_s = |pend_s;
    if (pend_s[11]) begin
      int_code_s = 4'd11;
    end else if (pend_s[3]) begin
      int_code_s = 4'd3;
    end else if (pend_s[7]) begin
      int_code_s = 4'd7;
    end else begin
      int_code_s = 4'd0;
    end
  end

  assign mip_o = mip_s;

  // Trap vector target; vectored offset only for interrupts in MODE 1
  always_comb begin
    tvec_base_s = {mtvec[XLEN-1:2], 2'b00};
    if ((VECTORED_EN != 0) && mcause_q[XLEN-1] && (mtvec[1:0] == 2'b01)) begin
      tvec_tgt_s = tvec_base_s + {{(XLEN-6){1'b0}}, mcause_q[3:0], 2'b00};
    end else begin
      tvec_tgt_s = tvec_base_s;
    end
  end

  // Next-state, trap-field capture and all sequencer outputs
  always_comb begin
    state_d      = state_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    csr_trap_we  = 1'b0;
    csr_mstat_we = 1'b0;
    mie_next     = 1'b0;
    mpie_next    = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = {XLEN{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          mepc_d   = {exc_pc[XLEN-1:2], 2'b00};
          mcause_d = {1'b0, {(XLEN-5){1'b0}}, exc_cause};
          mtval_d  = exc_tval;
          state_d  = ST_SAVE;
        end else if (mret_valid) begin
          // Gate with rst so nothing is asserted while reset is applied
          stall   = ~rst;
          state_d = ST_MRET;
        end else if (int_ok && int_any_s) begin
          mepc_d   = {int_pc[XLEN-1:2], 2'b00};
          mcause_d = {1'b1, {(XLEN-5){1'b0}}, int_code_s};
          mtval_d  = {XLEN{1'b0}};
          state_d  = ST_SAVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAVE: begin
        csr_trap_we  = 1'b1;
        csr_mstat_we = 1'b1;
        mie_next     = 1'b0;
        mpie_next    = mstatus_mie;
        stall        = 1'b1;
        state_d      = ST_REDIR;
      end
      ST_REDIR: begin
        redirect    = 1'b1;
        flush       = 1'b1;
        stall       = 1'b1;
        redirect_pc = tvec_tgt_s;
        state_d     = ST_IDLE;
      end
      ST_MRET: begin
        csr_mstat_we = 1'b1;
        mie_next     = mstatus_mpie;
        mpie_next    = 1'b1;
        redirect     = 1'b1;
        flush        = 1'b1;
        stall        = 1'b1;
        redirect_pc  = {mepc[XLEN-1:2], 2'b00};
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign csr_mepc_o   = mepc_q;
  assign csr_mcause_o = mcause_q;
  assign csr_mtval_o  = mtval_q;

  // State and latched trap fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mepc_q   <= {XLEN{1'b0}};
      mcause_q <= {XLEN{1'b0}};
      mtval_q  <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl: directed testbench for trap_ctrl with immediate assertions.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret_valid, int_ok;
  logic [31:0] int_pc;
  logic        irq_ext, irq_sw, irq_timer;
  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie, mtvec, mepc;
  logic        csr_trap_we, csr_mstat_we, mie_next, mpie_next;
  logic [31:0] csr_mepc_o, csr_mcause_o, csr_mtval_o, mip_o;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32), .SYNC_STAGES(2), .VECTORED_EN(1)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .int_ok(int_ok), .int_pc(int_pc),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .mie(mie), .mtvec(mtvec), .mepc(mepc),
    .csr_trap_we(csr_trap_we), .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o),
    .csr_mtval_o(csr_mtval_o), .csr_mstat_we(csr_mstat_we),
    .mie_next(mie_next), .mpie_next(mpie_next), .mip_o(mip_o),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; exc_valid = 1'b0; exc_cause = 4'd0; exc_pc = 32'h0; exc_tval = 32'h0;
    mret_valid = 1'b0; int_ok = 1'b0; int_pc = 32'h0;
    irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;
    mstatus_mie = 1'b0; mstatus_mpie = 1'b0; mie = 32'h0; mtvec = 32'h0; mepc = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_trap_we", {31'd0, csr_trap_we}, 32'd0);
    chk("rst_mstat_we", {31'd0, csr_mstat_we}, 32'd0);
    chk("rst_mcause", csr_mcause_o, 32'h0);
    chk("rst_mepc", csr_mepc_o, 32'h0);
    chk("rst_mtval", csr_mtval_o, 32'h0);
    chk("rst_mip", mip_o, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    rst = 1'b0;
    tick();

    // Exception: cause 2, direct mtvec
    mtvec = 32'h200; exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    #1 chk("exc_accept_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("exc_trap_we", {31'd0, csr_trap_we}, 32'd1);
    chk("exc_mcause", csr_mcause_o, 32'h2);
    chk("exc_mepc", csr_mepc_o, 32'h100);
    chk("exc_mtval", csr_mtval_o, 32'hDEAD);
    chk("exc_mstat_we", {31'd0, csr_mstat_we}, 32'd1);
    chk("exc_mie_next", {31'd0, mie_next}, 32'd0);
    chk("exc_mpie_next", {31'd0, mpie_next}, 32'd0);
    chk("exc_save_stall", {31'd0, stall}, 32'd1);
    chk("exc_save_noredir", {31'd0, redirect}, 32'd0);
    exc_valid = 1'b0;
    tick();
    chk("exc_redirect", {31'd0, redirect}, 32'd1);
    chk("exc_flush", {31'd0, flush}, 32'd1);
    chk("exc_redirect_pc", redirect_pc, 32'h200);
    chk("exc_redir_no_we", {31'd0, csr_trap_we}, 32'd0);
    tick();
    chk("exc_idle_redirect", {31'd0, redirect}, 32'd0);
    chk("exc_idle_stall", {31'd0, stall}, 32'd0);

    // Timer interrupt, vectored mtvec
    mstatus_mie = 1'b1; mie = 32'h80; int_ok = 1'b1; int_pc = 32'h44; mtvec = 32'h301;
    irq_timer = 1'b1;
    tick();
    chk("tmr_mip_sync1", mip_o, 32'h0);
    tick();
    chk("tmr_mip_sync2", mip_o, 32'h80);
    chk("tmr_not_yet", {31'd0, csr_trap_we}, 32'd0);
    tick();
    chk("tmr_trap_we", {31'd0, csr_trap_we}, 32'd1);
    chk("tmr_mcause", csr_mcause_o, 32'h80000007);
    chk("tmr_mepc", csr_mepc_o, 32'h44);
    chk("tmr_mtval", csr_mtval_o, 32'h0);
    chk("tmr_mie_next", {31'd0, mie_next}, 32'd0);
    chk("tmr_mpie_next", {31'd0, mpie_next}, 32'd1);
    irq_timer = 1'b0; mstatus_mie = 1'b0; mstatus_mpie = 1'b1;
    tick();
    chk("tmr_redirect_pc", redirect_pc, 32'h31C);
    tick();
    chk("tmr_mip_clear", mip_o, 32'h0);
    chk("tmr_idle_stall", {31'd0, stall}, 32'd0);

    // MEI and MSI together; MEI wins, then MSI after mret
    mie = 32'h808; mtvec = 32'h200; mstatus_mie = 1'b1; irq_ext = 1'b1; irq_sw = 1'b1;
    tick(); tick();
    chk("both_mip", mip_o, 32'h808);
    tick();
    chk("mei_mcause", csr_mcause_o, 32'h8000000B);
    chk("mei_mpie_next", {31'd0, mpie_next}, 32'd1);
    mstatus_mie = 1'b0; mstatus_mpie = 1'b1; irq_ext = 1'b0;
    tick();
    chk("mei_redirect_pc", redirect_pc, 32'h200);
    tick();
    chk("msi_mip_left", mip_o, 32'h8);
    chk("msi_masked_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("msi_masked_no_we", {31'd0, csr_trap_we}, 32'd0);
    mepc = 32'h1236; mret_valid = 1'b1;
    #1 chk("mret_accept_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("mret_mstat_we", {31'd0, csr_mstat_we}, 32'd1);
    chk("mret_mie_next", {31'd0, mie_next}, 32'd1);
    chk("mret_mpie_next", {31'd0, mpie_next}, 32'd1);
    chk("mret_redirect", {31'd0, redirect}, 32'd1);
    chk("mret_flush", {31'd0, flush}, 32'd1);
    chk("mret_redirect_pc", redirect_pc, 32'h1234);
    chk("mret_no_trap_we", {31'd0, csr_trap_we}, 32'd0);
    mret_valid = 1'b0; mstatus_mie = 1'b1;
    tick();
    chk("post_mret_redirect", {31'd0, redirect}, 32'd0);
    tick();
    chk("msi_trap_we", {31'd0, csr_trap_we}, 32'd1);
    chk("msi_mcause", csr_mcause_o, 32'h80000003);
    irq_sw = 1'b0; mstatus_mie = 1'b0;
    tick(); tick();

    // Exception + mret + pending irq at once: exception only
    mie = 32'h80; irq_timer = 1'b1; int_ok = 1'b0; mstatus_mie = 1'b1; mtvec = 32'h201;
    tick(); tick(); tick();
    chk("sim_mip", mip_o, 32'h80);
    chk("sim_no_int_without_ok", {31'd0, csr_trap_we}, 32'd0);
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h500; exc_tval = 32'h55;
    mret_valid = 1'b1; mepc = 32'h600; int_ok = 1'b1;
    #1 chk("sim_accept_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("sim_mcause", csr_mcause_o, 32'h5);
    chk("sim_mepc", csr_mepc_o, 32'h500);
    chk("sim_mtval", csr_mtval_o, 32'h55);
    exc_valid = 1'b0; mstatus_mie = 1'b0; mstatus_mpie = 1'b1; irq_timer = 1'b0;
    tick();
    chk("sim_exc_redirect_pc", redirect_pc, 32'h200);
    tick();
    chk("sim_mret_pending_stall", {31'd0, stall}, 32'd1);
    chk("sim_idle_no_we", {31'd0, csr_trap_we}, 32'd0);
    tick();
    chk("sim_mret_redirect_pc", redirect_pc, 32'h600);
    chk("sim_mret_mie_next", {31'd0, mie_next}, 32'd1);
    mret_valid = 1'b0; mstatus_mie = 1'b1;
    tick();
    chk("sim_end_redirect", {31'd0, redirect}, 32'd0);
    chk("sim_end_mip", mip_o, 32'h0);
    tick();
    chk("sim_no_late_int", {31'd0, csr_trap_we}, 32'd0);

    // Reset while in SAVE, then a normal exception
    mtvec = 32'h200; exc_valid = 1'b1; exc_cause = 4'd1; exc_pc = 32'h406; exc_tval = 32'h11;
    tick();
    chk("rs_save_we", {31'd0, csr_trap_we}, 32'd1);
    chk("rs_mepc_align", csr_mepc_o, 32'h404);
    rst = 1'b1;
    #1;
    chk("rs_async_we", {31'd0, csr_trap_we}, 32'd0);
    chk("rs_async_mstat_we", {31'd0, csr_mstat_we}, 32'd0);
    chk("rs_async_mcause", csr_mcause_o, 32'h0);
    chk("rs_async_mepc", csr_mepc_o, 32'h0);
    chk("rs_async_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("rs_held_we", {31'd0, csr_trap_we}, 32'd0);
    chk("rs_held_redirect", {31'd0, redirect}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rs_after_we", {31'd0, csr_trap_we}, 32'd1);
    chk("rs_after_mcause", csr_mcause_o, 32'h1);
    chk("rs_after_mepc", csr_mepc_o, 32'h404);
    chk("rs_after_mtval", csr_mtval_o, 32'h11);
    exc_valid = 1'b0;
    tick();
    chk("rs_after_redirect_pc", redirect_pc, 32'h200);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
